user_io_port: RTL and testbench
===============================

# user_io_port

Handshaking I/O port between the test computer's CPU and the board's human interface. On a CPU input request it blinks a "waiting" LED, waits for a key press, latches the switch value and acknowledges with a one-cycle pulse. On a CPU output write it holds the value for the two's-complement 7-segment display chain. Upstream it consumes the single-cycle pulse from the key debounce / falling-edge detector; downstream it feeds the decimal display.

## Interface
- WIDTH, 8, data width of the switch, input and output paths.
- BLINK_PERIOD, 12_500_000, clock cycles per `wait_led` half-period (0.25 s at 50 MHz); must be ≥ 2.
- clk  in  1  system clock (50 MHz).
- reset  in  1  synchronous, active-high; one clock; all state is cleared on a `clk` edge with `reset`=1.
- btn_pulse  in  1  single-cycle pulse per key press (debounced, edge-detected).
- sw  in  WIDTH  switch value, already synchronised to `clk`.
- in_req  in  1  CPU input request; level, held until `in_ack` is seen.
- in_data  out  WIDTH  captured switch value; stable until the next capture.
- in_ack  out  1  one-cycle acknowledge; `in_data` is valid when it is high.
- out_we  in  1  CPU output write strobe.
- out_wdata  in  WIDTH  CPU output data.
- out_reg  out  WIDTH  held output value, routed to the display.
- out_valid  out  1  0 until the first write, then 1; drives the display enable.
- wait_led  out  1  blinks while the port waits for a key press.

## Operation
- All outputs are registered. Reset values: `in_data`=0, `in_ack`=0, `out_reg`=0, `out_valid`=0, `wait_led`=0, FSM=IDLE, blink counter=0.
- FSM states: IDLE, WAIT, ACK, RELEASE.
  - IDLE: if `in_req`=1, go to WAIT, clear the blink counter and set `wait_led`=1. `btn_pulse` is ignored.
  - WAIT: if `in_req`=0 (abort), go to IDLE, set `wait_led`=0, no capture. Otherwise, if `btn_pulse`=1, set `in_data`←`sw`, `in_ack`←1, `wait_led`←0 and go to ACK. If abort and `btn_pulse` occur in the same cycle, abort wins.
  - ACK: `in_ack` is high for exactly this one cycle. Go to RELEASE unconditionally; `in_ack`←0.
  - RELEASE: wait for `in_req`=0, then go to IDLE. This is a 4-phase handshake; a held request never yields a second capture. `btn_pulse` is ignored.
- Blink: in WAIT only, the counter increments each cycle. At BLINK_PERIOD−1 it wraps to 0 and `wait_led` toggles. Outside WAIT, `wait_led`=0 and the counter is held at 0.
- Output path is independent of the FSM. When `out_we`=1: `out_reg`←`out_wdata` and `out_valid`←1. `out_valid` stays 1 until reset. A write is accepted in any FSM state, including the same cycle as a capture.
- Reset asserted mid-handshake returns to IDLE with all outputs at reset values. A pending request must be re-seen after reset: if `in_req` is still high, the FSM re-enters WAIT one cycle after reset is released.

## Timing
- `in_req` sampled high at edge k in IDLE: state=WAIT and `wait_led`=1 after edge k.
- `btn_pulse` sampled high at edge m in WAIT: `in_data`=`sw`(m) and `in_ack`=1 after edge m; `in_ack`=0 after edge m+1.
- `in_req` sampled low at edge r in RELEASE: IDLE after edge r. The earliest new request is accepted at edge r+1.
- `wait_led` first toggles (to 0) BLINK_PERIOD cycles after the WAIT entry edge, then every BLINK_PERIOD cycles.
- `out_we` at edge w: `out_reg` and `out_valid` update after edge w, giving 1 cycle of latency.
- `reset` has priority over every other input on the same edge.

## Test plan
- Reset, then idle for 10 cycles: all outputs 0. Pulse `btn_pulse` in IDLE: no `in_ack`, `in_data` stays 0x00.
- With BLINK_PERIOD=4: raise `in_req`, set `sw`=0xA5, wait 10 cycles, pulse `btn_pulse`. Required: `wait_led` is 1,1,1,1,0,0,0,0,1,1 from entry; `in_ack`=1 for exactly 1 cycle; `in_data`=0xA5; `wait_led`=0 after capture.
- Hold `in_req` high for 20 cycles after ack and pulse `btn_pulse` twice with `sw`=0x3C. Required: no second `in_ack`, `in_data` stays 0xA5. Drop `in_req`, then raise it again: WAIT is re-entered.
- In WAIT, drop `in_req` and pulse `btn_pulse` in the same cycle: return to IDLE, `in_ack` never asserts, `in_data` unchanged.
- `out_we` with `out_wdata`=0xF6 (−10): `out_reg`=0xF6 and `out_valid`=1 one cycle later. Issue a write in the same cycle as a capture: both take effect.
- Assert `reset` for 1 cycle while in ACK with `out_valid`=1: all outputs return to 0. With `in_req` still high, the FSM re-enters WAIT one cycle after reset is released.

Source files
------------

// File: rtl/user_io_port.sv
// user_io_port: CPU <-> human interface handshake port.
// Input path: 4-phase request/acknowledge with a blinking "waiting" LED,
// capturing the switches on a key press. Output path: a held display value
// with a valid flag set by the first write.
module user_io_port #(
  parameter int WIDTH        = 8,
  parameter int BLINK_PERIOD = 12_500_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_pulse,
  input  logic [WIDTH-1:0] sw,
  input  logic             in_req,
  output logic [WIDTH-1:0] in_data,
  output logic             in_ack,
  input  logic             out_we,
  input  logic [WIDTH-1:0] out_wdata,
  output logic [WIDTH-1:0] out_reg,
  output logic             out_valid,
  output logic             wait_led
);

  localparam int CW = (BLINK_PERIOD > 2) ? $clog2(BLINK_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_ACK     = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] in_data_q, in_data_d;
  logic            in_ack_q, in_ack_d;
  logic [WIDTH-1:0] out_reg_q, out_reg_d;
  logic            out_valid_q, out_valid_d;
  logic            wait_led_q, wait_led_d;

  // Next-state logic: handshake FSM with blink timer, plus the independent output path.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    in_data_d   = in_data_q;
    in_ack_d    = 1'b0;
    wait_led_d  = 1'b0;
    out_reg_d   = out_reg_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_req) begin
          state_d    = S_WAIT;
          wait_led_d = 1'b1;
        end
      end
      S_WAIT: begin
        // Abort has priority over a simultaneous key press.
        if (!in_req) begin
          state_d = S_IDLE;
        end else if (btn_pulse) begin
          state_d   = S_ACK;
          in_data_d = sw;
          in_ack_d  = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d      = '0;
          wait_led_d = ~wait_led_q;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          wait_led_d = wait_led_q;
        end
      end
      S_ACK: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // A held request must drop before another capture can happen.
        if (!in_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (out_we) begin
      out_reg_d   = out_wdata;
      out_valid_d = 1'b1;
    end
  end

  // State and registered outputs; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      in_data_q   <= '0;
      in_ack_q    <= 1'b0;
      out_reg_q   <= '0;
      out_valid_q <= 1'b0;
      wait_led_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_data_q   <= in_data_d;
      in_ack_q    <= in_ack_d;
      out_reg_q   <= out_reg_d;
      out_valid_q <= out_valid_d;
      wait_led_q  <= wait_led_d;
    end
  end

  assign in_data   = in_data_q;
  assign in_ack    = in_ack_q;
  assign out_reg   = out_reg_q;
  assign out_valid = out_valid_q;
  assign wait_led  = wait_led_q;

endmodule

// File: tb/tb_user_io_port.sv
// Bench for user_io_port: directed handshake scenarios with literal
// expectations, then randomized traffic, all checked every cycle against
// a behavioural model of the port.
module tb_user_io_port;

  localparam int W = 8;
  localparam int P = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         btn_pulse = 1'b0;
  logic [W-1:0] sw = '0;
  logic         in_req = 1'b0;
  logic [W-1:0] in_data;
  logic         in_ack;
  logic         out_we = 1'b0;
  logic [W-1:0] out_wdata = '0;
  logic [W-1:0] out_reg;
  logic         out_valid;
  logic         wait_led;

  user_io_port #(.WIDTH(W), .BLINK_PERIOD(P)) dut (
    .clk(clk), .reset(reset), .btn_pulse(btn_pulse), .sw(sw),
    .in_req(in_req), .in_data(in_data), .in_ack(in_ack),
    .out_we(out_we), .out_wdata(out_wdata), .out_reg(out_reg),
    .out_valid(out_valid), .wait_led(wait_led)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: the request is either unseen, being waited on (with
  // a count of cycles since it was seen), acknowledged this cycle, or
  // consumed and waiting for the CPU to drop it.
  bit         m_live = 0;
  bit         m_waiting = 0;
  int         m_wcycles = 0;
  bit         m_ack = 0;
  bit         m_consumed = 0;
  logic [W-1:0] m_in_data = '0;
  logic [W-1:0] m_out = '0;
  bit         m_ov = 0;

  function automatic bit model_led();
    return m_waiting && (((m_wcycles / P) % 2) == 0);
  endfunction

  // Advance the model on each edge and compare the DUT outputs just after it.
  always @(posedge clk) begin
    if (reset) begin
      m_live = 1; m_waiting = 0; m_wcycles = 0; m_ack = 0; m_consumed = 0;
      m_in_data = '0; m_out = '0; m_ov = 0;
    end else begin
      if (out_we) begin m_out = out_wdata; m_ov = 1; end
      if (m_ack) begin
        m_ack = 0; m_consumed = 1;
      end else if (m_consumed) begin
        if (!in_req) m_consumed = 0;
      end else if (m_waiting) begin
        if (!in_req) m_waiting = 0;
        else if (btn_pulse) begin m_waiting = 0; m_ack = 1; m_in_data = sw; end
        else m_wcycles++;
      end else if (in_req) begin
        m_waiting = 1; m_wcycles = 0;
      end
    end
    #1;
    if (m_live) begin
      check("in_data", in_data, m_in_data);
      check("in_ack", in_ack, m_ack);
      check("out_reg", out_reg, m_out);
      check("out_valid", out_valid, m_ov);
      check("wait_led", wait_led, model_led());
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  logic [9:0] led_log;
  logic [9:0] led_exp;

  initial begin
    // Reset and idle.
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (10) tick();
    check("idle_outputs", {in_data, in_ack, out_reg, out_valid, wait_led}, '0);
    btn_pulse = 1'b1; tick(); btn_pulse = 1'b0;
    check("idle_btn_ack", in_ack, 1'b0);
    check("idle_btn_data", in_data, 8'h00);

    // Request, blink pattern over 10 cycles, then capture.
    in_req = 1'b1; sw = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      tick(); led_log[9-i] = wait_led;
    end
    led_exp = 10'b1111000011;
    check("blink_pattern", led_log, led_exp);
    btn_pulse = 1'b1; tick(); btn_pulse = 1'b0;
    check("cap_ack", in_ack, 1'b1);
    check("cap_data", in_data, 8'hA5);
    check("cap_led", wait_led, 1'b0);
    tick();
    check("ack_one_cycle", in_ack, 1'b0);

    // Held request: no second capture.
    sw = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      btn_pulse = (i == 5 || i == 12);
      tick();
      check("held_no_ack", in_ack, 1'b0);
    end
    btn_pulse = 1'b0;
    check("held_data", in_data, 8'hA5);
    in_req = 1'b0; tick();
    in_req = 1'b1; tick();
    check("rewait_led", wait_led, 1'b1);
    tick();

    // Abort and key press in the same cycle: abort wins.
    in_req = 1'b0; btn_pulse = 1'b1; tick(); btn_pulse = 1'b0;
    check("abort_ack", in_ack, 1'b0);
    check("abort_led", wait_led, 1'b0);
    check("abort_data", in_data, 8'hA5);
    tick();
    check("abort_ack2", in_ack, 1'b0);

    // Output write of -10.
    out_we = 1'b1; out_wdata = 8'hF6; tick(); out_we = 1'b0;
    check("wr_reg", out_reg, 8'hF6);
    check("wr_valid", out_valid, 1'b1);

    // Write coincident with a capture.
    in_req = 1'b1; tick();
    sw = 8'h5A; btn_pulse = 1'b1; out_we = 1'b1; out_wdata = 8'h11; tick();
    btn_pulse = 1'b0; out_we = 1'b0;
    check("both_ack", in_ack, 1'b1);
    check("both_data", in_data, 8'h5A);
    check("both_reg", out_reg, 8'h11);

    // Reset while in ACK with the request still held.
    reset = 1'b1; tick(); reset = 1'b0;
    check("rst_outputs", {in_data, in_ack, out_reg, out_valid, wait_led}, '0);
    tick();
    check("rst_rewait", wait_led, 1'b1);
    in_req = 1'b0; tick();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) in_req = ~in_req;
      btn_pulse = ($urandom_range(0, 5) == 0);
      sw        = W'($urandom);
      out_we    = ($urandom_range(0, 7) == 0);
      out_wdata = W'($urandom);
      reset     = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; btn_pulse = 1'b0; out_we = 1'b0;
    tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
